axi4_lite_ctrl_arbiter: RTL and testbench
=========================================

Name: axi4_lite_ctrl_arbiter

Overview:
- Shares the single control port of the AXI4-Lite master between NUM_REQ requesters.
- Grants one request at a time in round-robin order, issues it as a one-cycle write or read request pulse, and waits for the master's done pulse.
- Returns read data and response to the granted requester.
- A watchdog aborts a requester's wait if the master hangs, then drains the master before the next grant.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 256, max WAIT cycles before error completion; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request; command held stable until its req_done.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*32  packed addresses; requester i uses [32i+31:32i].
- req_wdata  in  NUM_REQ*32  packed write data.
- req_wstrb  in  NUM_REQ*4  packed byte strobes.
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_rdata  out  32  read data; valid while req_done is asserted.
- req_resp  out  2  AXI response; valid while req_done is asserted.
- req_timeout  out  1  asserted together with req_done when the completion came from the watchdog.
- m_addr  out  32  to master ctrl_addr.
- m_wdata  out  32  to master ctrl_wdata.
- m_wstrb  out  4  to master ctrl_wstrb.
- m_write_req  out  1  to master ctrl_write_req.
- m_read_req  out  1  to master ctrl_read_req.
- m_rdata  in  32  from master ctrl_rdata.
- m_write_done  in  1  from master ctrl_write_done (one-cycle pulse).
- m_read_done  in  1  from master ctrl_read_done (one-cycle pulse).
- m_resp  in  2  from master ctrl_resp.
- busy  out  1  high whenever state is not IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last grant.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs go to 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 wins first.
  - Watchdog counter clears.
  - Reset mid-transaction abandons it with no req_done; the master is not drained.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - If any req_valid is high, pick the first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - Register grant_id and last, latch that requester's write/addr/wdata/wstrb into m_*, then go to ISSUE.
  - m_write_done and m_read_done are ignored in IDLE.
- ISSUE:
  - Exactly one cycle.
  - m_write_req=1 if the latched write bit is 1, else m_read_req=1; never both.
  - Clear the watchdog and go to WAIT.
  - A matching done in this cycle is accepted as in WAIT.
- WAIT:
  - Matching done (m_write_done for write, m_read_done for read): capture m_rdata (write: force 0) and m_resp, then go to RESP.
  - A non-matching done is ignored.
  - Otherwise increment the watchdog.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 without a done: req_resp=2'b10, req_rdata=0, req_timeout=1, then go to RESP with drain flag set.
- RESP:
  - req_done[grant_id]=1 for exactly one cycle; req_rdata, req_resp and req_timeout are valid.
  - Next state is DRAIN if drain is flagged, else IDLE.
  - Outside RESP, req_done=0, req_timeout=0, and req_rdata/req_resp hold their last values.
- DRAIN: wait for the matching master done (data discarded), then go to IDLE; no watchdog runs here.
- Latency: grant in IDLE cycle T, request pulse in T+1, done seen in D, req_done in D+1, IDLE in D+2.
- Back-to-back: the next grant is evaluated in D+2, so a requester that drops req_valid one cycle after req_done is not re-granted.
- m_addr, m_wdata and m_wstrb stay stable from ISSUE until the next grant.
- Changes to req_* of a non-granted requester never affect the in-flight transaction.

Test Plan:
- Single write: req0 write addr=0x10, data=0xDEADBEEF, wstrb=0xF; master done 3 cycles after the pulse. Expect m_write_req high 1 cycle, m_addr=0x10, req_done[0] one cycle after done, resp=0, busy returns to 0.
- Read: req2 read 0x20 with m_rdata=0x12345678, m_resp=0. Expect req_rdata=0x12345678 when req_done[2] pulses, and m_read_req only.
- Fairness: all four requesters held valid continuously. Expect grant order 0,1,2,3,0,...; after a reset, req3 alone then req1+req3 gives order 3,1,3.
- Simultaneous arrival: req1 and req2 assert in the same cycle right after reset. Expect 1 then 2, with no overlap of the two requests' request pulses.
- Timeout: TIMEOUT_CYCLES=8, master never responds. Expect req_done with resp=2'b10 and req_timeout=1 eight cycles after ISSUE, busy stays high in DRAIN, and a late done returns the block to IDLE with no second req_done.
- Reset mid-WAIT: assert rst for 1 cycle during WAIT. Expect all outputs 0, no req_done, and the next grant goes to requester 0 when several requesters are valid.

Source files
------------

// File: rtl/axi4_lite_ctrl_arbiter_if.sv
// Requester-side and AXI4-Lite-master-side signal bundle for the control-port arbiter.
// The arbiter takes the master modport; the environment takes the slave modport.
interface axi4_lite_ctrl_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_write;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ*4-1:0]  req_wstrb;
    logic [NUM_REQ-1:0]    req_done;
    logic [31:0]           req_rdata;
    logic [1:0]            req_resp;
    logic                  req_timeout;
    logic [31:0]           m_addr;
    logic [31:0]           m_wdata;
    logic [3:0]            m_wstrb;
    logic                  m_write_req;
    logic                  m_read_req;
    logic [31:0]           m_rdata;
    logic                  m_write_done;
    logic                  m_read_done;
    logic [1:0]            m_resp;
    logic                  busy;
    logic [IW-1:0]         grant_id;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_done, req_rdata, req_resp, req_timeout,
        output m_addr, m_wdata, m_wstrb, m_write_req, m_read_req,
        input  m_rdata, m_write_done, m_read_done, m_resp,
        output busy, grant_id
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_done, req_rdata, req_resp, req_timeout,
        input  m_addr, m_wdata, m_wstrb, m_write_req, m_read_req,
        output m_rdata, m_write_done, m_read_done, m_resp,
        input  busy, grant_id
    );
endinterface

// File: rtl/axi4_lite_ctrl_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master control port between NUM_REQ requesters,
// with a watchdog that error-completes a hung request and drains the master afterwards.
module axi4_lite_ctrl_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                       clk,
    input logic                       rst,
    axi4_lite_ctrl_arbiter_if.master  bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [31:0] TLIM = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN
    } state_t;

    state_t      r_state, w_next;
    logic [IW-1:0] r_last, r_gid, w_pick;
    logic        w_found;
    logic        r_write;
    logic [31:0] r_addr, r_wdata, r_rdata, r_wdog;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_resp;
    logic        r_to, r_drain;
    logic        w_match, w_expire, w_cap, w_tout;

    // Search starts just after the last grant so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            automatic int idx = (int'(r_last) + k) % NUM_REQ;
            if (!w_found && bus.req_valid[idx]) begin
                w_found = 1'b1;
                w_pick  = IW'(idx);
            end
        end
    end

    assign w_match  = r_write ? bus.m_write_done : bus.m_read_done;
    assign w_expire = (TIMEOUT_CYCLES != 0) && ((r_wdog + 32'd1) >= TLIM);

    always_comb begin
        w_next = r_state;
        w_cap  = 1'b0;
        w_tout = 1'b0;
        unique case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: begin
                if (w_match) begin
                    w_cap  = 1'b1;
                    w_next = S_RESP;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_match) begin
                    w_cap  = 1'b1;
                    w_next = S_RESP;
                end else if (w_expire) begin
                    w_tout = 1'b1;
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = r_drain ? S_DRAIN : S_IDLE;
            S_DRAIN: if (w_match) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= IW'(NUM_REQ - 1);
            r_gid   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_resp  <= '0;
            r_to    <= 1'b0;
            r_drain <= 1'b0;
            r_wdog  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_found) begin
                r_gid   <= w_pick;
                r_last  <= w_pick;
                r_write <= bus.req_write[w_pick];
                r_addr  <= bus.req_addr[int'(w_pick)*32 +: 32];
                r_wdata <= bus.req_wdata[int'(w_pick)*32 +: 32];
                r_wstrb <= bus.req_wstrb[int'(w_pick)*4 +: 4];
            end
            if (r_state == S_ISSUE)
                r_wdog <= '0;
            else if (r_state == S_WAIT)
                r_wdog <= r_wdog + 32'd1;
            if (w_cap) begin
                r_rdata <= r_write ? 32'd0 : bus.m_rdata;
                r_resp  <= bus.m_resp;
                r_to    <= 1'b0;
                r_drain <= 1'b0;
            end
            if (w_tout) begin
                r_rdata <= '0;
                r_resp  <= 2'b10;
                r_to    <= 1'b1;
                r_drain <= 1'b1;
            end
        end
    end

    assign bus.m_write_req = (r_state == S_ISSUE) && r_write;
    assign bus.m_read_req  = (r_state == S_ISSUE) && !r_write;
    assign bus.m_addr      = r_addr;
    assign bus.m_wdata     = r_wdata;
    assign bus.m_wstrb     = r_wstrb;
    assign bus.req_done    = (r_state == S_RESP) ? (NUM_REQ'(1) << r_gid) : '0;
    assign bus.req_timeout = (r_state == S_RESP) && r_to;
    assign bus.req_rdata   = r_rdata;
    assign bus.req_resp    = r_resp;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.grant_id    = r_gid;
endmodule

// File: tb/tb_axi4_lite_ctrl_arbiter.sv
// Directed bench for axi4_lite_ctrl_arbiter: a master model, expectation queues filled
// by the stimulus, and a negedge monitor that checks every request pulse and req_done.
module tb_axi4_lite_ctrl_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_lite_ctrl_arbiter_if #(.NUM_REQ(N)) bus ();

    axi4_lite_ctrl_arbiter #(
        .NUM_REQ(N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          id;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } iss_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        to;
        int          lat;
    } dn_t;

    iss_t q_iss[$];
    dn_t  q_dn[$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int last_iss = 0;
    logic prev_pulse = 1'b0;
    logic hold = 1'b0;

    int          m_delay  = 3;
    logic [31:0] m_rd_val = '0;
    logic [1:0]  m_rp_val = '0;
    int          m_cnt    = 0;
    logic        m_wr     = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Master model: answers each request pulse with a matching done m_delay cycles later.
    assign bus.m_rdata = m_rd_val;
    assign bus.m_resp  = m_rp_val;

    always @(posedge clk) begin
        bus.m_write_done <= 1'b0;
        bus.m_read_done  <= 1'b0;
        if (rst) begin
            m_cnt <= 0;
        end else if (m_cnt != 0) begin
            if (m_cnt == 1) begin
                if (m_wr) bus.m_write_done <= 1'b1;
                else      bus.m_read_done  <= 1'b1;
            end
            m_cnt <= m_cnt - 1;
        end else if (bus.m_write_req || bus.m_read_req) begin
            m_wr  <= bus.m_write_req;
            m_cnt <= m_delay - 1;
        end
    end

    always @(negedge clk) begin
        iss_t ei;
        dn_t  ed;
        logic pulse;
        cyc++;
        pulse = bus.m_write_req | bus.m_read_req;
        if (pulse) begin
            chk("req_both", 64'(bus.m_write_req & bus.m_read_req), 0);
            chk("req_len", 64'(prev_pulse), 0);
            if (q_iss.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_issue grant=%0d addr=%0h", bus.grant_id, bus.m_addr);
            end else begin
                ei = q_iss.pop_front();
                chk("grant_id", 64'(bus.grant_id), 64'(ei.id));
                chk("issue_wr", 64'(bus.m_write_req), 64'(ei.wr));
                chk("m_addr", 64'(bus.m_addr), 64'(ei.addr));
                chk("m_wdata", 64'(bus.m_wdata), 64'(ei.wdata));
                chk("m_wstrb", 64'(bus.m_wstrb), 64'(ei.wstrb));
            end
            last_iss = cyc;
        end
        prev_pulse = pulse;
        if (bus.req_done != '0) begin
            if (q_dn.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done req_done=%0h", bus.req_done);
            end else begin
                ed = q_dn.pop_front();
                chk("req_done", 64'(bus.req_done), 64'(1) << ed.id);
                chk("req_rdata", 64'(bus.req_rdata), 64'(ed.rdata));
                chk("req_resp", 64'(bus.req_resp), 64'(ed.resp));
                chk("req_timeout", 64'(bus.req_timeout), 64'(ed.to));
                chk("latency", 64'(cyc - last_iss), 64'(ed.lat));
            end
        end
    end

    task automatic set_req(int i, logic wr, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        bus.req_write[i] = wr;
        bus.req_addr[i*32 +: 32]  = a;
        bus.req_wdata[i*32 +: 32] = d;
        bus.req_wstrb[i*4 +: 4]   = s;
    endtask

    task automatic expect_txn(int i, logic wr, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                              logic [31:0] rd, logic [1:0] rp, logic to, int lat);
        iss_t ei;
        dn_t  ed;
        ei.id = i; ei.wr = wr; ei.addr = a; ei.wdata = d; ei.wstrb = s;
        ed.id = i; ed.rdata = rd; ed.resp = rp; ed.to = to; ed.lat = lat;
        q_iss.push_back(ei);
        q_dn.push_back(ed);
    endtask

    task automatic service(int budget);
        logic [N-1:0] ds;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            ds = bus.req_done;
            @(posedge clk);
            #1;
            if (!hold) bus.req_valid = bus.req_valid & ~ds;
            else if (q_dn.size() == 0) bus.req_valid = '0;
            if (bus.req_valid == '0 && !bus.busy) return;
        end
        checks++;
        fails++;
        $display("FAIL service_timeout valid=%0h busy=%0b", bus.req_valid, bus.busy);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_zero(string t);
        chk({t, "_done"}, 64'(bus.req_done), 0);
        chk({t, "_rdata"}, 64'(bus.req_rdata), 0);
        chk({t, "_resp_to"}, 64'({bus.req_resp, bus.req_timeout}), 0);
        chk({t, "_maddr"}, 64'({bus.m_addr, bus.m_wstrb}), 0);
        chk({t, "_mwdata"}, 64'(bus.m_wdata), 0);
        chk({t, "_mreq"}, 64'({bus.m_write_req, bus.m_read_req}), 0);
        chk({t, "_busy_gid"}, 64'({bus.busy, bus.grant_id}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single write; read data from master must be forced to zero
        m_delay = 3; m_rd_val = 32'hBAD0_BAD0; m_rp_val = 2'b00;
        set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        expect_txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00, 1'b0, 4);
        bus.req_valid = 4'b0001;
        service(50);
        chk("busy_after_write", 64'(bus.busy), 0);

        // single read
        m_rd_val = 32'h1234_5678;
        set_req(2, 1'b0, 32'h20, 32'h0, 4'h0);
        expect_txn(2, 1'b0, 32'h20, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 1'b0, 4);
        bus.req_valid = 4'b0100;
        service(50);

        // fairness with all four held valid
        pulse_reset();
        m_delay = 2; m_rd_val = 32'h0;
        for (int i = 0; i < N; i++)
            set_req(i, 1'b1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                expect_txn(i, 1'b1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF,
                           32'h0, 2'b00, 1'b0, 3);
        hold = 1'b1;
        bus.req_valid = 4'b1111;
        service(200);
        hold = 1'b0;

        // req3 alone, then req1 joins: order 3,1,3
        pulse_reset();
        m_rd_val = 32'h33;
        set_req(3, 1'b0, 32'h300, 32'h0, 4'h0);
        set_req(1, 1'b1, 32'h104, 32'h11, 4'h3);
        expect_txn(3, 1'b0, 32'h300, 32'h0, 4'h0, 32'h33, 2'b00, 1'b0, 3);
        expect_txn(1, 1'b1, 32'h104, 32'h11, 4'h3, 32'h0, 2'b00, 1'b0, 3);
        expect_txn(3, 1'b0, 32'h300, 32'h0, 4'h0, 32'h33, 2'b00, 1'b0, 3);
        hold = 1'b1;
        bus.req_valid = 4'b1000;
        @(posedge clk);
        #1;
        bus.req_valid = 4'b1010;
        service(200);
        hold = 1'b0;

        // simultaneous arrival right after reset, slave error response
        pulse_reset();
        m_rd_val = 32'hCAFE_F00D; m_rp_val = 2'b01;
        set_req(1, 1'b0, 32'h44, 32'h0, 4'h0);
        set_req(2, 1'b1, 32'h48, 32'h22, 4'hC);
        expect_txn(1, 1'b0, 32'h44, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b01, 1'b0, 3);
        expect_txn(2, 1'b1, 32'h48, 32'h22, 4'hC, 32'h0, 2'b01, 1'b0, 3);
        bus.req_valid = 4'b0110;
        service(100);

        // watchdog: done arrives only after the timeout, during DRAIN
        m_delay = 20; m_rp_val = 2'b00; m_rd_val = 32'h55;
        set_req(0, 1'b0, 32'h80, 32'h0, 4'h0);
        expect_txn(0, 1'b0, 32'h80, 32'h0, 4'h0, 32'h0, 2'b10, 1'b1, 8);
        bus.req_valid = 4'b0001;
        for (int c = 0; c < 100 && q_dn.size() != 0; c++) @(negedge clk);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        repeat (4) @(negedge clk);
        chk("busy_drain", 64'(bus.busy), 1);
        chk("drain_no_done", 64'({bus.req_done, bus.req_timeout}), 0);
        service(100);
        chk("resp_hold", 64'(bus.req_resp), 64'(2'b10));

        // reset in the middle of WAIT
        m_delay = 30;
        set_req(1, 1'b1, 32'h40, 32'h44, 4'hF);
        begin
            iss_t ei;
            ei.id = 1; ei.wr = 1'b1; ei.addr = 32'h40; ei.wdata = 32'h44; ei.wstrb = 4'hF;
            q_iss.push_back(ei);
        end
        bus.req_valid = 4'b0010;
        for (int c = 0; c < 50 && q_iss.size() != 0; c++) @(negedge clk);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_delay = 2; m_rd_val = 32'h77;
        set_req(0, 1'b0, 32'h200, 32'h0, 4'h0);
        set_req(3, 1'b1, 32'h208, 32'h99, 4'h1);
        expect_txn(0, 1'b0, 32'h200, 32'h0, 4'h0, 32'h77, 2'b00, 1'b0, 3);
        expect_txn(1, 1'b1, 32'h40, 32'h44, 4'hF, 32'h0, 2'b00, 1'b0, 3);
        expect_txn(3, 1'b1, 32'h208, 32'h99, 4'h1, 32'h0, 2'b00, 1'b0, 3);
        bus.req_valid = 4'b1011;
        @(negedge clk);
        check_zero("midrst");
        service(200);

        repeat (5) @(negedge clk);
        chk("queues_empty", 64'(q_iss.size() + q_dn.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
